// File: rtl/score_display.sv
// Score display: sequential double-dabble BCD conversion, session high score
// tracking and four-digit multiplexed seven-segment drive (active-low).
module score_display #(
    parameter int SCORE_W  = 10,
    parameter int SCAN_DIV = 50000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [SCORE_W-1:0] score,
    input  logic               lose,
    input  logic               show_high,
    output logic [3:0]         an,
    output logic [6:0]         cathodes,
    output logic               dp,
    output logic [15:0]        bcd,
    output logic               busy
);

    localparam int CNT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int ITER_W = $clog2(SCORE_W + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(SCAN_DIV - 1);
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(SCORE_W - 1);
    localparam logic [6:0]        SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // ---------------- high score ----------------
    logic [SCORE_W-1:0] hi_q;
    logic               lose_q;
    logic               lose_rise;

    assign lose_rise = lose & ~lose_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q   <= '0;
            lose_q <= 1'b0;
        end else begin
            lose_q <= lose;
            if (lose_rise && (score > hi_q))
                hi_q <= score;
        end
    end

    // ---------------- conversion FSM ----------------
    logic [SCORE_W-1:0] src;
    logic [SCORE_W-1:0] last_src_q;
    logic [SCORE_W-1:0] sh_q;
    logic [15:0]        scratch_q;
    logic [15:0]        scratch_d;
    logic [ITER_W-1:0]  iter_q;
    logic [15:0]        bcd_q;
    logic               busy_q;
    state_t             state_q;

    assign src = show_high ? hi_q : score;

    // Add-3 correction is applied before the shift so every digit stays <= 9.
    for (genvar gi = 0; gi < 4; gi++) begin : g_adj
        assign scratch_d[gi*4 +: 4] = (scratch_q[gi*4 +: 4] >= 4'd5)
                                    ? scratch_q[gi*4 +: 4] + 4'd3
                                    : scratch_q[gi*4 +: 4];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            last_src_q <= '0;
            sh_q       <= '0;
            scratch_q  <= '0;
            iter_q     <= '0;
            bcd_q      <= '0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (src != last_src_q) begin
                        sh_q       <= src;
                        last_src_q <= src;
                        scratch_q  <= '0;
                        iter_q     <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch_q <= {scratch_d[14:0], sh_q[SCORE_W-1]};
                    sh_q      <= {sh_q[SCORE_W-2:0], 1'b0};
                    iter_q    <= iter_q + 1'b1;
                    if (iter_q == ITER_LAST)
                        state_q <= DONE;
                end
                DONE: begin
                    bcd_q   <= scratch_q;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // ---------------- digit scan ----------------
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       idx_q;
    logic [3:0]       an_q;
    logic [6:0]       cath_q;
    logic             dp_q;
    logic [3:0]       blank;
    logic [3:0]       digit;

    assign blank[3] = (bcd_q[15:12] == 4'd0);
    assign blank[2] = blank[3] && (bcd_q[11:8] == 4'd0);
    assign blank[1] = blank[2] && (bcd_q[7:4] == 4'd0);
    assign blank[0] = 1'b0;
    assign digit    = bcd_q[idx_q*4 +: 4];

    // an, cathodes and dp all derive from idx_q so they switch on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            idx_q  <= 2'd0;
            an_q   <= 4'b1110;
            cath_q <= 7'b0000001;
            dp_q   <= 1'b1;
        end else begin
            if (cnt_q == CNT_MAX) begin
                cnt_q <= '0;
                idx_q <= idx_q + 2'd1;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
            an_q   <= ~(4'b0001 << idx_q);
            cath_q <= blank[idx_q] ? SEG_BLANK : seg7(digit);
            dp_q   <= ~((idx_q == 2'd0) && show_high);
        end
    end

    assign an       = an_q;
    assign cathodes = cath_q;
    assign dp       = dp_q;
    assign bcd      = bcd_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_score_display.sv
// Directed bench for score_display: latency, BCD values, scan patterns,
// leading-zero blanking, high-score tracking and reset abort.
module tb_score_display;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  score = '0;
    logic        lose = 1'b0;
    logic        show_high = 1'b0;
    logic [3:0]  an;
    logic [6:0]  cathodes;
    logic        dp;
    logic [15:0] bcd;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [6:0] slot_cath [4];
    logic       slot_dp   [4];
    logic       slot_seen [4];
    logic       bad_an;

    score_display #(.SCORE_W(10), .SCAN_DIV(4)) dut (
        .clk(clk), .reset(reset), .score(score), .lose(lose),
        .show_high(show_high), .an(an), .cathodes(cathodes), .dp(dp),
        .bcd(bcd), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Observe a full scan round and record what each anode slot displayed.
    task automatic collect_scan();
        for (int s = 0; s < 4; s++) begin
            slot_seen[s] = 1'b0;
            slot_cath[s] = 'x;
            slot_dp[s]   = 'x;
        end
        bad_an = 1'b0;
        for (int k = 0; k < 24; k++) begin
            tick(1);
            case (an)
                4'b1110: begin slot_seen[0] = 1'b1; slot_cath[0] = cathodes; slot_dp[0] = dp; end
                4'b1101: begin slot_seen[1] = 1'b1; slot_cath[1] = cathodes; slot_dp[1] = dp; end
                4'b1011: begin slot_seen[2] = 1'b1; slot_cath[2] = cathodes; slot_dp[2] = dp; end
                4'b0111: begin slot_seen[3] = 1'b1; slot_cath[3] = cathodes; slot_dp[3] = dp; end
                default: bad_an = 1'b1;
            endcase
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        n_cmp++; if (an !== 4'b1110) begin n_bad++; $display("FAIL reset_an got=%b exp=1110", an); end
        n_cmp++; if (cathodes !== 7'b0000001) begin n_bad++; $display("FAIL reset_cath got=%b exp=0000001", cathodes); end
        n_cmp++; if (dp !== 1'b1) begin n_bad++; $display("FAIL reset_dp got=%b exp=1", dp); end
        n_cmp++; if (bcd !== 16'h0000) begin n_bad++; $display("FAIL reset_bcd got=%h exp=0000", bcd); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        $display("test_reset: an=%b cath=%b dp=%b bcd=%h busy=%b", an, cathodes, dp, bcd, busy);
    endtask

    task automatic test_conversion_507();
        int k_done = 0;
        int busy_cnt = 0;
        logic [6:0] exp_c [4];
        exp_c[0] = 7'b0001111; exp_c[1] = 7'b0000001;
        exp_c[2] = 7'b0100100; exp_c[3] = 7'b1111111;
        score = 10'd507;
        for (int k = 1; k <= 20; k++) begin
            tick(1);
            if (busy === 1'b1) busy_cnt++;
            if (bcd === 16'h0507 && k_done == 0) k_done = k;
        end
        n_cmp++; if (k_done != 12) begin n_bad++; $display("FAIL conv507_latency got=%0d exp=12", k_done); end
        n_cmp++; if (busy_cnt != 11) begin n_bad++; $display("FAIL conv507_busy_cycles got=%0d exp=11", busy_cnt); end
        n_cmp++; if (bcd !== 16'h0507) begin n_bad++; $display("FAIL conv507_bcd got=%h exp=0507", bcd); end
        collect_scan();
        n_cmp++; if (bad_an) begin n_bad++; $display("FAIL conv507_an_onehot got=illegal exp=onehot-low"); end
        for (int s = 0; s < 4; s++) begin
            n_cmp++;
            if (slot_seen[s] !== 1'b1 || slot_cath[s] !== exp_c[s]) begin
                n_bad++; $display("FAIL conv507_slot%0d got=%b exp=%b", s, slot_cath[s], exp_c[s]);
            end
        end
        n_cmp++; if (slot_dp[0] !== 1'b1) begin n_bad++; $display("FAIL conv507_dp got=%b exp=1", slot_dp[0]); end
        $display("test_conversion_507: latency=%0d busy=%0d bcd=%h", k_done, busy_cnt, bcd);
    endtask

    task automatic test_max_value();
        logic [6:0] exp_c [4];
        exp_c[0] = 7'b0000110; exp_c[1] = 7'b0010010;
        exp_c[2] = 7'b0000001; exp_c[3] = 7'b1001111;
        score = 10'd1023;
        tick(14);
        n_cmp++; if (bcd !== 16'h1023) begin n_bad++; $display("FAIL max_bcd got=%h exp=1023", bcd); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL max_busy got=%b exp=0", busy); end
        collect_scan();
        for (int s = 0; s < 4; s++) begin
            n_cmp++;
            if (slot_seen[s] !== 1'b1 || slot_cath[s] !== exp_c[s]) begin
                n_bad++; $display("FAIL max_slot%0d got=%b exp=%b", s, slot_cath[s], exp_c[s]);
            end
        end
        $display("test_max_value: bcd=%h", bcd);
    endtask

    task automatic test_back_to_back();
        int k100 = 0;
        int k101 = 0;
        logic busy13 = 1'b0;
        score = 10'd100;
        for (int k = 1; k <= 30; k++) begin
            tick(1);
            if (k == 3) score = 10'd101;
            if (k == 13) busy13 = busy;
            if (bcd === 16'h0100 && k100 == 0) k100 = k;
            if (bcd === 16'h0101 && k101 == 0) k101 = k;
        end
        n_cmp++; if (k100 != 12) begin n_bad++; $display("FAIL b2b_first got=%0d exp=12", k100); end
        n_cmp++; if (k101 == 0 || k101 > 24) begin n_bad++; $display("FAIL b2b_second got=%0d exp<=24", k101); end
        n_cmp++; if (busy13 !== 1'b1) begin n_bad++; $display("FAIL b2b_busy_reassert got=%b exp=1", busy13); end
        $display("test_back_to_back: first=%0d second=%0d final=%h", k100, k101, bcd);
    endtask

    task automatic test_high_score();
        logic [6:0] exp_c [4];
        logic       exp_d [4];
        exp_c[0] = 7'b0010010; exp_c[1] = 7'b1001100;
        exp_c[2] = 7'b1111111; exp_c[3] = 7'b1111111;
        exp_d[0] = 1'b0; exp_d[1] = 1'b1; exp_d[2] = 1'b1; exp_d[3] = 1'b1;
        score = 10'd42;
        tick(2);
        lose = 1'b1; tick(1); lose = 1'b0;
        tick(14);
        score = 10'd30;
        tick(2);
        lose = 1'b1; tick(1); lose = 1'b0;
        tick(14);
        n_cmp++; if (bcd !== 16'h0030) begin n_bad++; $display("FAIL hi_live_bcd got=%h exp=0030", bcd); end
        show_high = 1'b1;
        tick(14);
        n_cmp++; if (bcd !== 16'h0042) begin n_bad++; $display("FAIL hi_shown_bcd got=%h exp=0042", bcd); end
        collect_scan();
        for (int s = 0; s < 4; s++) begin
            n_cmp++;
            if (slot_seen[s] !== 1'b1 || slot_cath[s] !== exp_c[s]) begin
                n_bad++; $display("FAIL hi_slot%0d got=%b exp=%b", s, slot_cath[s], exp_c[s]);
            end
            n_cmp++;
            if (slot_dp[s] !== exp_d[s]) begin
                n_bad++; $display("FAIL hi_dp%0d got=%b exp=%b", s, slot_dp[s], exp_d[s]);
            end
        end
        $display("test_high_score: bcd=%h", bcd);
    endtask

    task automatic test_reset_mid_conversion();
        logic [6:0] exp_c [4];
        exp_c[0] = 7'b0000100; exp_c[1] = 7'b0000100;
        exp_c[2] = 7'b0000100; exp_c[3] = 7'b1111111;
        show_high = 1'b0;
        score = 10'd999;
        tick(5);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rstmid_busy_before got=%b exp=1", busy); end
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        n_cmp++; if (bcd !== 16'h0000) begin n_bad++; $display("FAIL rstmid_bcd got=%h exp=0000", bcd); end
        n_cmp++; if (an !== 4'b1110 || cathodes !== 7'b0000001 || dp !== 1'b1) begin
            n_bad++; $display("FAIL rstmid_display got=%b/%b/%b exp=1110/0000001/1", an, cathodes, dp);
        end
        tick(14);
        n_cmp++; if (bcd !== 16'h0999) begin n_bad++; $display("FAIL rstmid_reconv got=%h exp=0999", bcd); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy_after got=%b exp=0", busy); end
        collect_scan();
        for (int s = 0; s < 4; s++) begin
            n_cmp++;
            if (slot_seen[s] !== 1'b1 || slot_cath[s] !== exp_c[s]) begin
                n_bad++; $display("FAIL rstmid_slot%0d got=%b exp=%b", s, slot_cath[s], exp_c[s]);
            end
        end
        $display("test_reset_mid_conversion: bcd=%h", bcd);
    endtask

    initial begin
        test_reset();
        test_conversion_507();
        test_max_value();
        test_back_to_back();
        test_high_score();
        test_reset_mid_conversion();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/score_display.md
Name: score_display

Overview:
- Downstream consumer of the game score and the lose flag.
- Converts the 10-bit binary score to BCD with a sequential double-dabble engine, replacing the combinational /10 and %10 logic.
- Tracks the session high score and multiplexes four digits onto the board's seven-segment display: active-low anodes, active-low cathodes.
- Sits between the coin/obstacle logic (score, lose) and the SSD pins.

Parameters:
- SCORE_W, 10: width of the binary score input. Max value 1023 fits in 4 BCD digits.
- SCAN_DIV, 50000: clk cycles per digit slot. Legal range 2..2^20.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- score  in  SCORE_W  live game score (binary).
- lose  in  1  game-over level from obstacle logic.
- show_high  in  1  1 = display the high score, 0 = display the live score.
- an  out  4  anodes, active-low one-hot; an[0] = ones digit.
- cathodes  out  7  {Ca..Cg}, active-low.
- dp  out  1  decimal point, active-low.
- bcd  out  16  last converted value; [15:12] thousands … [3:0] ones.
- busy  out  1  high while a conversion is in progress.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values (all registers):
  - an=4'b1110, cathodes=7'b0000001, dp=1, bcd=0, busy=0
  - hi_score=0, last_src=0, scan counter=0, digit index=0
  - lose_d=0, FSM=IDLE
- Source select: src = show_high ? hi_score : score (combinational).
- High score:
  - lose_rise = lose & ~lose_d; lose_d is registered every cycle.
  - On lose_rise, if score > hi_score (unsigned), then hi_score <= score.
  - Runs independently of the conversion FSM.
- Conversion FSM:
  - IDLE: if src != last_src, capture sh <= src, last_src <= src, clear scratch BCD, busy <= 1, go to SHIFT with iteration count 0. Otherwise stay.
  - SHIFT: each cycle, add 3 to every scratch BCD digit >= 5, then shift {scratch, sh} left by 1. Increment count. After SCORE_W shifts go to DONE.
  - DONE: bcd <= scratch, busy <= 0, go to IDLE.
  - Latency: the src change is visible at clk edge N; bcd updates at edge N+SCORE_W+2 (12 cycles for the default).
  - src changes during SHIFT/DONE are ignored. The re-compare happens in IDLE, so the final bcd always matches the final stable src.
- Scan:
  - Counter runs 0..SCAN_DIV-1. At wrap, digit index increments mod 4.
  - an and cathodes are registered from the same index, so they change on the same edge. No cycle shows mismatched digit/pattern.
- Digit patterns (active-low {Ca..Cg}):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
- Leading-zero blanking:
  - Digit 3 is blank (1111111) if it is 0.
  - Digit 2 is blank if digits 3..2 are 0.
  - Digit 1 is blank if digits 3..1 are 0.
  - Digit 0 is never blanked.
- dp = 0 only when index=0 and show_high=1 (high-score indicator); otherwise 1.
- Reset mid-conversion: the FSM aborts. Next cycle all outputs are at reset values. A new conversion starts only if src != 0.

Test Plan:
- Reset: assert reset for 2 cycles -> an=1110, cathodes=0000001, dp=1, bcd=0, busy=0.
- Conversion: score=507 (SCAN_DIV=4) -> busy high for 11 cycles; bcd=16'h0507 at edge 12. Scan sequence an=1110/1101/1011/0111 with cathodes 0001111 / 0000001 / 0100100 / 1111111 (the 0 in digit 1 is not blanked).
- Max value: score=1023 -> bcd=16'h1023, all four digits lit (1001111, 0000001, 0010010, 0000110).
- High score: score=42, pulse lose -> hi_score=42. Then score=30, pulse lose -> hi_score stays 42. Set show_high=1 -> bcd=16'h0042; dp=0 only in the an=1110 slot; digits 3..2 blank.
- Mid-conversion change: score=100, change to 101 three cycles later -> bcd reads 0100 first, then 0101 within 24 cycles of the first change; busy re-asserts.
- Reset mid-conversion: score=999, assert reset at cycle 5 of SHIFT -> busy=0 and bcd=0 next cycle. After reset drops with score=999, a full conversion -> bcd=16'h0999.
